// File: rtl/multicycle_control_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit_pkg
// Description : Shared encodings for the multicycle MIPS control unit and its
//               integer datapath: sequencer states, instruction classes,
//               opcode/funct values, ALU function codes and selector values.
// Revision    : 1.0 - initial release
// ============================================================================
package multicycle_control_unit_pkg;

  // Sequencer states
  typedef enum logic [4:0] {
    ST_RESET  = 5'd0,
    ST_FETCH  = 5'd1,
    ST_DECODE = 5'd2,
    ST_EX_R   = 5'd3,
    ST_EX_I   = 5'd4,
    ST_WB_ALU = 5'd5,
    ST_ADDR   = 5'd6,
    ST_MEM_RD = 5'd7,
    ST_WB_MEM = 5'd8,
    ST_MEM_WR = 5'd9,
    ST_BRANCH = 5'd10,
    ST_JUMP   = 5'd11,
    ST_JAL    = 5'd12,
    ST_JR     = 5'd13,
    ST_MULDIV = 5'd14,
    ST_MF     = 5'd15,
    ST_HALT   = 5'd16
  } state_t;

  // Instruction classes produced by the decoder
  typedef enum logic [3:0] {
    CLS_ALU_R   = 4'd0,
    CLS_ALU_I   = 4'd1,
    CLS_LOAD    = 4'd2,
    CLS_STORE   = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_JUMP    = 4'd5,
    CLS_JAL     = 4'd6,
    CLS_JR      = 4'd7,
    CLS_MULDIV  = 4'd8,
    CLS_MF      = 4'd9,
    CLS_BREAK   = 4'd10,
    CLS_ILLEGAL = 4'd11
  } instr_class_t;

  // Primary opcodes
  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_J     = 6'h02;
  localparam logic [5:0] c_OP_JAL   = 6'h03;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_BNE   = 6'h05;
  localparam logic [5:0] c_OP_ADDI  = 6'h08;
  localparam logic [5:0] c_OP_SLTI  = 6'h0A;
  localparam logic [5:0] c_OP_ANDI  = 6'h0C;
  localparam logic [5:0] c_OP_ORI   = 6'h0D;
  localparam logic [5:0] c_OP_LUI   = 6'h0F;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2B;

  // R-type funct values
  localparam logic [5:0] c_FN_JR    = 6'h08;
  localparam logic [5:0] c_FN_BREAK = 6'h0D;
  localparam logic [5:0] c_FN_MFHI  = 6'h10;
  localparam logic [5:0] c_FN_MFLO  = 6'h12;
  localparam logic [5:0] c_FN_MULT  = 6'h18;
  localparam logic [5:0] c_FN_DIV   = 6'h1A;
  localparam logic [5:0] c_FN_ADD   = 6'h20;
  localparam logic [5:0] c_FN_ADDU  = 6'h21;
  localparam logic [5:0] c_FN_SUB   = 6'h22;
  localparam logic [5:0] c_FN_SUBU  = 6'h23;
  localparam logic [5:0] c_FN_AND   = 6'h24;
  localparam logic [5:0] c_FN_OR    = 6'h25;
  localparam logic [5:0] c_FN_SLT   = 6'h2A;

  // ALU function codes
  localparam logic [4:0] c_FS_PASS = 5'h00;
  localparam logic [4:0] c_FS_ADD  = 5'h02;
  localparam logic [4:0] c_FS_SUB  = 5'h03;
  localparam logic [4:0] c_FS_SLT  = 5'h06;
  localparam logic [4:0] c_FS_AND  = 5'h08;
  localparam logic [4:0] c_FS_OR   = 5'h09;
  localparam logic [4:0] c_FS_LUI  = 5'h0E;
  localparam logic [4:0] c_FS_MUL  = 5'h1E;
  localparam logic [4:0] c_FS_DIV  = 5'h1F;

  // PC source select
  localparam logic [1:0] c_PC_SEL_ALU  = 2'd0;
  localparam logic [1:0] c_PC_SEL_JUMP = 2'd1;
  localparam logic [1:0] c_PC_SEL_RS   = 2'd2;
  localparam logic [1:0] c_PC_SEL_VEC  = 2'd3;

  // Register-file destination select
  localparam logic [1:0] c_D_SEL_RD  = 2'd0;
  localparam logic [1:0] c_D_SEL_RT  = 2'd1;
  localparam logic [1:0] c_D_SEL_R31 = 2'd2;

  // Write-back source select
  localparam logic [2:0] c_Y_SEL_HI  = 3'd0;
  localparam logic [2:0] c_Y_SEL_LO  = 3'd1;
  localparam logic [2:0] c_Y_SEL_ALU = 3'd2;
  localparam logic [2:0] c_Y_SEL_DIN = 3'd3;
  localparam logic [2:0] c_Y_SEL_PC  = 3'd4;

  // Operand source selects
  localparam logic [1:0] c_T_SEL_RT  = 2'd0;
  localparam logic [1:0] c_T_SEL_IMM = 2'd1;
  localparam logic       c_S_SEL_RS  = 1'b0;

endpackage

`default_nettype wire

// File: rtl/multicycle_control_unit_decode.sv
`default_nettype none
// ============================================================================
// Module      : mcu_decode
// Description : Combinational instruction decoder. Maps the opcode and funct
//               fields to an instruction class and the ALU function code used
//               by the execute / address / branch / multiply states.
// Revision    : 1.0 - initial release
// ============================================================================
module mcu_decode
  import multicycle_control_unit_pkg::*;
(
  input  logic [5:0]   i_opcode,
  input  logic [5:0]   i_funct,
  output instr_class_t o_cls,
  output logic [4:0]   o_fs
);

  // Classify the instruction; anything not listed falls through as illegal
  always_comb begin
    o_cls = CLS_ILLEGAL;
    o_fs  = c_FS_PASS;
    case (i_opcode)
      c_OP_RTYPE: begin
        case (i_funct)
          c_FN_ADD, c_FN_ADDU: begin o_cls = CLS_ALU_R;  o_fs = c_FS_ADD; end
          c_FN_SUB, c_FN_SUBU: begin o_cls = CLS_ALU_R;  o_fs = c_FS_SUB; end
          c_FN_AND:            begin o_cls = CLS_ALU_R;  o_fs = c_FS_AND; end
          c_FN_OR:             begin o_cls = CLS_ALU_R;  o_fs = c_FS_OR;  end
          c_FN_SLT:            begin o_cls = CLS_ALU_R;  o_fs = c_FS_SLT; end
          c_FN_JR:             o_cls = CLS_JR;
          c_FN_MULT:           begin o_cls = CLS_MULDIV; o_fs = c_FS_MUL; end
          c_FN_DIV:            begin o_cls = CLS_MULDIV; o_fs = c_FS_DIV; end
          c_FN_MFHI, c_FN_MFLO: o_cls = CLS_MF;
          c_FN_BREAK:          o_cls = CLS_BREAK;
          default:             o_cls = CLS_ILLEGAL;
        endcase
      end
      c_OP_ADDI:         begin o_cls = CLS_ALU_I;  o_fs = c_FS_ADD; end
      c_OP_SLTI:         begin o_cls = CLS_ALU_I;  o_fs = c_FS_SLT; end
      c_OP_ANDI:         begin o_cls = CLS_ALU_I;  o_fs = c_FS_AND; end
      c_OP_ORI:          begin o_cls = CLS_ALU_I;  o_fs = c_FS_OR;  end
      c_OP_LUI:          begin o_cls = CLS_ALU_I;  o_fs = c_FS_LUI; end
      c_OP_LW:           begin o_cls = CLS_LOAD;   o_fs = c_FS_ADD; end
      c_OP_SW:           begin o_cls = CLS_STORE;  o_fs = c_FS_ADD; end
      c_OP_BEQ, c_OP_BNE: begin o_cls = CLS_BRANCH; o_fs = c_FS_SUB; end
      c_OP_J:            o_cls = CLS_JUMP;
      c_OP_JAL:          o_cls = CLS_JAL;
      default:           o_cls = CLS_ILLEGAL;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit
// Description : Sequencer for the multicycle MIPS integer datapath. Steps each
//               instruction through fetch / decode / execute / memory /
//               write-back and issues the per-state datapath and memory
//               controls. Memory states stall on mem_rdy.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic        Z,
  input  logic        mem_rdy,
  output logic        pc_ld,
  output logic        pc_inc,
  output logic [1:0]  pc_sel,
  output logic        ir_ld,
  output logic        im_cs,
  output logic        im_rd,
  output logic        dm_cs,
  output logic        dm_rd,
  output logic        dm_wr,
  output logic        D_En,
  output logic [1:0]  D_sel,
  output logic [1:0]  T_Sel,
  output logic        S_Sel,
  output logic [2:0]  Y_Sel,
  output logic [4:0]  FS,
  output logic        HILO_ld,
  output logic        FLAG_ld,
  output logic        halt,
  output logic        illegal
);

  state_t       r_state;
  instr_class_t w_cls;
  logic [4:0]   w_fs;
  logic         w_taken;
  logic         w_unused_bits;

  mcu_decode u_decode (
    .i_opcode (IR[31:26]),
    .i_funct  (IR[5:0]),
    .o_cls    (w_cls),
    .o_fs     (w_fs)
  );

  // The vector value itself lives in the datapath; this unit only selects it
  // via pc_sel, and the register / immediate fields are routed there directly.
  assign w_unused_bits = ^{IR[25:6], RESET_VEC};

  // Branch decision: beq on zero, bne on non-zero
  assign w_taken = ((IR[31:26] == c_OP_BEQ) &&  Z) ||
                   ((IR[31:26] == c_OP_BNE) && !Z);

  // State register: reset parks in RESET, memory states hold until mem_rdy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RESET;
    end else begin
      case (r_state)
        ST_RESET:  r_state <= ST_FETCH;
        ST_FETCH:  if (mem_rdy) r_state <= ST_DECODE;
        ST_DECODE: begin
          case (w_cls)
            CLS_ALU_R:  r_state <= ST_EX_R;
            CLS_ALU_I:  r_state <= ST_EX_I;
            CLS_LOAD,
            CLS_STORE:  r_state <= ST_ADDR;
            CLS_BRANCH: r_state <= ST_BRANCH;
            CLS_JUMP:   r_state <= ST_JUMP;
            CLS_JAL:    r_state <= ST_JAL;
            CLS_JR:     r_state <= ST_JR;
            CLS_MULDIV: r_state <= ST_MULDIV;
            CLS_MF:     r_state <= ST_MF;
            default:    r_state <= ST_HALT;
          endcase
        end
        ST_EX_R,
        ST_EX_I:   r_state <= ST_WB_ALU;
        ST_ADDR:   r_state <= (w_cls == CLS_LOAD) ? ST_MEM_RD : ST_MEM_WR;
        ST_MEM_RD: if (mem_rdy) r_state <= ST_WB_MEM;
        ST_MEM_WR: if (mem_rdy) r_state <= ST_FETCH;
        ST_HALT:   r_state <= ST_HALT;
        ST_WB_ALU, ST_WB_MEM, ST_BRANCH, ST_JUMP,
        ST_JAL, ST_JR, ST_MULDIV, ST_MF:
                   r_state <= ST_FETCH;
        default:   r_state <= ST_RESET;
      endcase
    end
  end

  // Per-state controls; everything is forced idle while reset is held so an
  // aborted instruction can never write
  always_comb begin
    pc_ld   = 1'b0;
    pc_inc  = 1'b0;
    pc_sel  = c_PC_SEL_ALU;
    ir_ld   = 1'b0;
    im_cs   = 1'b0;
    im_rd   = 1'b0;
    dm_cs   = 1'b0;
    dm_rd   = 1'b0;
    dm_wr   = 1'b0;
    D_En    = 1'b0;
    D_sel   = c_D_SEL_RD;
    T_Sel   = c_T_SEL_RT;
    S_Sel   = c_S_SEL_RS;
    Y_Sel   = c_Y_SEL_HI;
    FS      = c_FS_PASS;
    HILO_ld = 1'b0;
    FLAG_ld = 1'b0;
    halt    = 1'b0;
    illegal = 1'b0;
    if (reset) begin
      case (r_state)
        ST_RESET: begin
          pc_sel = c_PC_SEL_VEC;
          pc_ld  = 1'b1;
        end
        ST_FETCH: begin
          im_cs  = 1'b1;
          im_rd  = 1'b1;
          ir_ld  = mem_rdy;
          pc_inc = mem_rdy;
        end
        ST_DECODE: begin
          T_Sel = c_T_SEL_RT;
          S_Sel = c_S_SEL_RS;
        end
        ST_EX_R: begin
          FS    = w_fs;
          D_sel = c_D_SEL_RD;
        end
        ST_EX_I: begin
          T_Sel = c_T_SEL_IMM;
          FS    = w_fs;
          D_sel = c_D_SEL_RT;
        end
        ST_WB_ALU: begin
          T_Sel = (w_cls == CLS_ALU_I) ? c_T_SEL_IMM : c_T_SEL_RT;
          FS    = w_fs;
          D_sel = (w_cls == CLS_ALU_I) ? c_D_SEL_RT : c_D_SEL_RD;
          Y_Sel = c_Y_SEL_ALU;
          D_En  = 1'b1;
        end
        ST_ADDR: begin
          T_Sel = c_T_SEL_IMM;
          FS    = w_fs;
        end
        ST_MEM_RD: begin
          dm_cs = 1'b1;
          dm_rd = 1'b1;
        end
        ST_WB_MEM: begin
          Y_Sel = c_Y_SEL_DIN;
          D_sel = c_D_SEL_RT;
          D_En  = 1'b1;
        end
        ST_MEM_WR: begin
          dm_cs = 1'b1;
          dm_wr = 1'b1;
        end
        ST_BRANCH: begin
          FS = w_fs;
          if (w_taken) begin
            pc_sel = c_PC_SEL_ALU;
            pc_ld  = 1'b1;
          end
        end
        ST_JUMP: begin
          pc_sel = c_PC_SEL_JUMP;
          pc_ld  = 1'b1;
        end
        ST_JAL: begin
          Y_Sel  = c_Y_SEL_PC;
          D_sel  = c_D_SEL_R31;
          D_En   = 1'b1;
          pc_sel = c_PC_SEL_JUMP;
          pc_ld  = 1'b1;
        end
        ST_JR: begin
          pc_sel = c_PC_SEL_RS;
          pc_ld  = 1'b1;
        end
        ST_MULDIV: begin
          FS      = w_fs;
          HILO_ld = 1'b1;
        end
        ST_MF: begin
          Y_Sel = (IR[5:0] == c_FN_MFHI) ? c_Y_SEL_HI : c_Y_SEL_LO;
          D_sel = c_D_SEL_RD;
          D_En  = 1'b1;
        end
        ST_HALT: begin
          halt    = 1'b1;
          illegal = (w_cls == CLS_ILLEGAL);
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control_unit
// Description : Self-checking bench for multicycle_control_unit. Random
//               instructions and wait states are scored against a per-
//               instruction reference table of cycle counts and strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;
  import multicycle_control_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IR;
  logic        Z, mem_rdy;
  logic        pc_ld, pc_inc, ir_ld, im_cs, im_rd, dm_cs, dm_rd, dm_wr;
  logic        D_En, S_Sel, HILO_ld, FLAG_ld, halt, illegal;
  logic [1:0]  pc_sel, D_sel, T_Sel;
  logic [2:0]  Y_Sel;
  logic [4:0]  FS;

  always #5 clk = ~clk;

  multicycle_control_unit #(.RESET_VEC(32'h100)) dut (
    .clk(clk), .reset(reset), .IR(IR), .Z(Z), .mem_rdy(mem_rdy),
    .pc_ld(pc_ld), .pc_inc(pc_inc), .pc_sel(pc_sel), .ir_ld(ir_ld),
    .im_cs(im_cs), .im_rd(im_rd), .dm_cs(dm_cs), .dm_rd(dm_rd), .dm_wr(dm_wr),
    .D_En(D_En), .D_sel(D_sel), .T_Sel(T_Sel), .S_Sel(S_Sel), .Y_Sel(Y_Sel),
    .FS(FS), .HILO_ld(HILO_ld), .FLAG_ld(FLAG_ld), .halt(halt), .illegal(illegal)
  );

  // Instruction kinds of the reference model
  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BNE = 5;
  localparam int K_J = 6, K_JAL = 7, K_JR = 8, K_MD = 9, K_MFHI = 10, K_MFLO = 11;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         kind;
    logic [4:0] fs;
  } ins_t;

  typedef struct {
    logic       den, pcld, pcinc, irld, hilo, dmrd, dmwr, imrd, flag, hlt, ill;
    logic [1:0] dsel, pcsel;
    logic [2:0] ysel;
    logic [4:0] fs;
  } smp_t;

  ins_t tbl[$];
  int   total = 0;
  int   bad   = 0;
  int   cur_id = -1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s (instr %0d) observed=%0h expected=%0h", tag, cur_id, got, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, sample outputs just after
  task automatic step(input logic [31:0] ir, input logic zf, input logic rdy, output smp_t o);
    @(negedge clk);
    IR = ir; Z = zf; mem_rdy = rdy;
    #1;
    o.den = D_En;   o.pcld = pc_ld;  o.pcinc = pc_inc; o.irld = ir_ld;
    o.hilo = HILO_ld; o.dmrd = dm_rd; o.dmwr = dm_wr; o.imrd = im_rd;
    o.flag = FLAG_ld; o.hlt = halt;   o.ill = illegal;
    o.dsel = D_sel; o.pcsel = pc_sel; o.ysel = Y_Sel;  o.fs = FS;
  endtask

  // Run one instruction from FETCH and score it against the reference rules
  task automatic run_instr(input int id, input int fw, input int mw, input logic zf);
    ins_t e;
    smp_t s[12];
    logic [31:0] ir;
    logic rdy, taken;
    int n, memc, den_c, exp_den, exp_pcld, exp_hilo;
    int c_den, c_pcld, c_irld, c_pcinc, c_hilo, c_dmrd, c_dmwr, c_imrd, c_misc;
    logic [1:0] exp_dsel, exp_pcsel;
    logic [2:0] exp_ysel;
    e = tbl[id];
    cur_id = id;
    ir = {e.op, 20'($urandom), (e.op == 6'h00) ? e.fn : 6'($urandom)};
    memc = -1; exp_den = 0; den_c = 0; exp_pcld = 0; exp_hilo = 0;
    exp_dsel = 2'd0; exp_ysel = 3'd0; exp_pcsel = 2'd0;
    taken = ((e.kind == K_BEQ) && zf) || ((e.kind == K_BNE) && !zf);
    case (e.kind)
      K_R, K_I: begin n = 4 + fw; exp_den = 1; den_c = fw + 3;
                      exp_dsel = (e.kind == K_R) ? 2'd0 : 2'd1; exp_ysel = 3'd2; end
      K_LW:     begin n = 5 + fw + mw; memc = fw + 3; exp_den = 1; den_c = fw + 4 + mw;
                      exp_dsel = 2'd1; exp_ysel = 3'd3; end
      K_SW:     begin n = 4 + fw + mw; memc = fw + 3; end
      K_BEQ, K_BNE: begin n = 3 + fw; exp_pcld = taken ? 1 : 0; exp_pcsel = 2'd0; end
      K_J:      begin n = 3 + fw; exp_pcld = 1; exp_pcsel = 2'd1; end
      K_JAL:    begin n = 3 + fw; exp_pcld = 1; exp_pcsel = 2'd1; exp_den = 1;
                      den_c = fw + 2; exp_dsel = 2'd2; exp_ysel = 3'd4; end
      K_JR:     begin n = 3 + fw; exp_pcld = 1; exp_pcsel = 2'd2; end
      K_MD:     begin n = 3 + fw; exp_hilo = 1; end
      default:  begin n = 3 + fw; exp_den = 1; den_c = fw + 2; exp_dsel = 2'd0;
                      exp_ysel = (e.kind == K_MFHI) ? 3'd0 : 3'd1; end
    endcase
    c_den = 0; c_pcld = 0; c_irld = 0; c_pcinc = 0; c_hilo = 0;
    c_dmrd = 0; c_dmwr = 0; c_imrd = 0; c_misc = 0;
    for (int c = 0; c < n; c++) begin
      if (c < fw)                                        rdy = 1'b0;
      else if (c == fw)                                  rdy = 1'b1;
      else if (memc >= 0 && c >= memc && c < memc + mw) rdy = 1'b0;
      else if (memc >= 0 && c == memc + mw)              rdy = 1'b1;
      else                                               rdy = 1'($urandom);
      step(ir, zf, rdy, s[c]);
      c_den += int'(s[c].den);   c_pcld += int'(s[c].pcld); c_irld += int'(s[c].irld);
      c_pcinc += int'(s[c].pcinc); c_hilo += int'(s[c].hilo); c_dmrd += int'(s[c].dmrd);
      c_dmwr += int'(s[c].dmwr); c_imrd += int'(s[c].imrd);
      c_misc += int'(s[c].flag) + int'(s[c].hlt) + int'(s[c].ill);
    end
    chk("ir_ld count", c_irld, 1);
    chk("ir_ld at fetch done", s[fw].irld, 1'b1);
    chk("pc_inc count", c_pcinc, 1);
    chk("im_rd cycles", c_imrd, fw + 1);
    chk("D_En count", c_den, exp_den);
    if (exp_den != 0) begin
      chk("D_En cycle", s[den_c].den, 1'b1);
      chk("D_sel at write", s[den_c].dsel, exp_dsel);
      chk("Y_Sel at write", s[den_c].ysel, exp_ysel);
    end
    chk("pc_ld count", c_pcld, exp_pcld);
    if (exp_pcld != 0) begin
      chk("pc_ld cycle", s[fw + 2].pcld, 1'b1);
      chk("pc_sel at load", s[fw + 2].pcsel, exp_pcsel);
    end
    chk("HILO_ld count", c_hilo, exp_hilo);
    chk("dm_rd cycles", c_dmrd, (e.kind == K_LW) ? mw + 1 : 0);
    chk("dm_wr cycles", c_dmwr, (e.kind == K_SW) ? mw + 1 : 0);
    chk("flag/halt/illegal quiet", c_misc, 0);
    if (e.kind <= K_BNE || e.kind == K_MD)
      chk("FS in execute", s[fw + 2].fs, e.fs);
    if (e.kind == K_R || e.kind == K_I)
      chk("FS at write-back", s[den_c].fs, e.fs);
  endtask

  // Fetch a stopping instruction, then confirm HALT is absorbing
  task automatic run_halt(input logic [31:0] ir, input logic exp_ill);
    smp_t a;
    step(ir, 1'b0, 1'b1, a);
    chk("halt-path ir_ld", a.irld, 1'b1);
    step(ir, 1'b0, 1'($urandom), a);
    chk("halt not yet in decode", a.hlt, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(ir, 1'($urandom), 1'($urandom), a);
      chk("halt held", a.hlt, 1'b1);
      chk("illegal flag", a.ill, exp_ill);
      chk("no fetch in halt", a.imrd, 1'b0);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reset pc_ld", pc_ld, 1'b1);
    chk("reset pc_sel", pc_sel, 2'd3);
    chk("reset no fetch", im_rd, 1'b0);
  endtask

  initial begin
    smp_t a;
    logic [31:0] lw_ir;
    tbl.push_back('{6'h00, 6'h20, K_R,   c_FS_ADD}); // 0 add
    tbl.push_back('{6'h00, 6'h21, K_R,   c_FS_ADD}); // 1 addu
    tbl.push_back('{6'h00, 6'h22, K_R,   c_FS_SUB}); // 2 sub
    tbl.push_back('{6'h00, 6'h23, K_R,   c_FS_SUB}); // 3 subu
    tbl.push_back('{6'h00, 6'h24, K_R,   c_FS_AND}); // 4 and
    tbl.push_back('{6'h00, 6'h25, K_R,   c_FS_OR});  // 5 or
    tbl.push_back('{6'h00, 6'h2A, K_R,   c_FS_SLT}); // 6 slt
    tbl.push_back('{6'h08, 6'h00, K_I,   c_FS_ADD}); // 7 addi
    tbl.push_back('{6'h0A, 6'h00, K_I,   c_FS_SLT}); // 8 slti
    tbl.push_back('{6'h0C, 6'h00, K_I,   c_FS_AND}); // 9 andi
    tbl.push_back('{6'h0D, 6'h00, K_I,   c_FS_OR});  // 10 ori
    tbl.push_back('{6'h0F, 6'h00, K_I,   c_FS_LUI}); // 11 lui
    tbl.push_back('{6'h23, 6'h00, K_LW,  c_FS_ADD}); // 12 lw
    tbl.push_back('{6'h2B, 6'h00, K_SW,  c_FS_ADD}); // 13 sw
    tbl.push_back('{6'h04, 6'h00, K_BEQ, c_FS_SUB}); // 14 beq
    tbl.push_back('{6'h05, 6'h00, K_BNE, c_FS_SUB}); // 15 bne
    tbl.push_back('{6'h02, 6'h00, K_J,   c_FS_PASS}); // 16 j
    tbl.push_back('{6'h03, 6'h00, K_JAL, c_FS_PASS}); // 17 jal
    tbl.push_back('{6'h00, 6'h08, K_JR,  c_FS_PASS}); // 18 jr
    tbl.push_back('{6'h00, 6'h18, K_MD,  c_FS_MUL}); // 19 mult
    tbl.push_back('{6'h00, 6'h1A, K_MD,  c_FS_DIV}); // 20 div
    tbl.push_back('{6'h00, 6'h10, K_MFHI, c_FS_PASS}); // 21 mfhi
    tbl.push_back('{6'h00, 6'h12, K_MFLO, c_FS_PASS}); // 22 mflo

    reset = 1'b0; IR = 32'h0; Z = 1'b0; mem_rdy = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("in reset pc_ld", pc_ld, 1'b0);
    chk("in reset im_rd", im_rd, 1'b0);
    chk("in reset halt", halt, 1'b0);
    chk("in reset illegal", illegal, 1'b0);
    release_reset();

    // Directed: add, lw with two memory waits, beq taken / not taken, jal
    run_instr(0, 0, 0, 1'b0);
    run_instr(12, 0, 2, 1'b0);
    run_instr(14, 0, 0, 1'b1);
    run_instr(14, 0, 0, 1'b0);
    run_instr(17, 0, 0, 1'b0);
    run_instr(13, 1, 1, 1'b1);

    // Random instruction stream with random fetch / memory wait states
    repeat (40)
      run_instr($urandom_range(0, 22), $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));

    // Reset in the middle of a stalled load aborts without a write
    cur_id = 12;
    lw_ir = {6'h23, 26'($urandom)};
    step(lw_ir, 1'b0, 1'b1, a);
    step(lw_ir, 1'b0, 1'b0, a);
    step(lw_ir, 1'b0, 1'b0, a);
    step(lw_ir, 1'b0, 1'b0, a);
    chk("stalled load dm_rd", a.dmrd, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("abort dm_rd", dm_rd, 1'b0);
    chk("abort D_En", D_En, 1'b0);
    release_reset();
    run_instr(5, 0, 0, 1'b0);

    // break halts without the illegal flag
    cur_id = -2;
    run_halt({6'h00, 20'($urandom), 6'h0D}, 1'b0);
    #2 reset = 1'b0;
    release_reset();

    // Unsupported opcode halts with illegal; reset clears both at once
    cur_id = -3;
    run_halt({6'h3F, 26'($urandom)}, 1'b1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("reset clears halt", halt, 1'b0);
    chk("reset clears illegal", illegal, 1'b0);
    release_reset();
    run_instr(7, 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
